// File: rtl/bus_pkg.sv
// Shared bus definitions: master-requester states, default widths and
// response flag layout reused by the slave side.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } mreq_state_e;

  localparam int BUS_AW_DEFAULT = 16;
  localparam int BUS_DW_DEFAULT = 8;

  // Response flag vector: error qualifier and completion strobe.
  localparam int RSP_ERR_BIT = 0;
  localparam int RSP_VLD_BIT = 1;
  localparam int RSP_FLAG_W  = 2;

endpackage

// File: rtl/bus_master_requester_if.sv
// Local command/response, arbiter handshake and system-bus transfer signals
// of one master port; master = requester view, slave = environment view.
interface bus_master_requester_if
  import bus_pkg::*;
#(
  parameter int AW = BUS_AW_DEFAULT,
  parameter int DW = BUS_DW_DEFAULT
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic          BREQ;
  logic          BGRANT;

  logic          bus_valid;
  logic          bus_write;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ready;
  logic [DW-1:0] bus_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  BGRANT, bus_ready, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output BREQ, bus_valid, bus_write, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output BGRANT, bus_ready, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  BREQ, bus_valid, bus_write, bus_addr, bus_wdata
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// Saturating wait-state counter; expired flags the cycle on which the count
// would reach TIMEOUT, so the owning state lasts exactly TIMEOUT cycles.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;

  assign w_next  = r_count + 1'b1;
  assign expired = enable && (w_next == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != CW'(TIMEOUT))) begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/bus_master_requester.sv
// Master-side requester in front of the two-master arbiter: one command,
// BREQ/BGRANT handshake, single bus transfer. Wait-state abort under MASTER_TIMEOUT_EN.
module bus_master_requester
  import bus_pkg::*;
#(
  parameter int AW      = BUS_AW_DEFAULT,
  parameter int DW      = BUS_DW_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  bus_master_requester_if.master bif
);

  mreq_state_e            r_state;
  mreq_state_e            w_state_nxt;
  logic                   w_accept;
  logic                   w_enter_release;
  logic                   w_err_nxt;
  logic                   w_capture_rd;
  logic                   w_expired;

  logic                   r_write;
  logic [AW-1:0]          r_addr;
  logic [DW-1:0]          r_wdata;
  logic [DW-1:0]          r_rdata;
  logic [RSP_FLAG_W-1:0]  r_rsp_flags;

  assign w_accept = (r_state == IDLE) && bif.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // bus_ready outranks a simultaneous grant loss; grant outranks a timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_err_nxt    = 1'b0;
    w_capture_rd = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bif.req_valid) w_state_nxt = REQUEST;
      end
      REQUEST: begin
        if (bif.BGRANT) begin
          w_state_nxt = XFER;
        end else if (w_expired) begin
          w_state_nxt = RELEASE;
          w_err_nxt   = 1'b1;
        end
      end
      XFER: begin
        if (bif.bus_ready) begin
          w_state_nxt  = RELEASE;
          w_capture_rd = ~r_write;
        end else if (!bif.BGRANT || w_expired) begin
          w_state_nxt = RELEASE;
          w_err_nxt   = 1'b1;
        end
      end
      RELEASE: begin
        if (!bif.BGRANT) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter_release = (w_state_nxt == RELEASE) && (r_state != RELEASE);

`ifdef MASTER_TIMEOUT_EN
  logic w_to_clear;
  logic w_to_enable;

  assign w_to_clear  = (w_state_nxt != r_state) &&
                       ((w_state_nxt == REQUEST) || (w_state_nxt == XFER));
  assign w_to_enable = (r_state == REQUEST) || (r_state == XFER);

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_to_clear),
    .enable  (w_to_enable),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Command and read data are plain data registers; outputs gate them to 0.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= bif.req_write;
      r_addr  <= bif.req_addr;
      r_wdata <= bif.req_wdata;
    end
    if (w_enter_release) begin
      r_rdata <= w_capture_rd ? bif.bus_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_flags <= '0;
    end else begin
      r_rsp_flags <= '0;
      if (w_enter_release) begin
        r_rsp_flags[RSP_VLD_BIT] <= 1'b1;
        r_rsp_flags[RSP_ERR_BIT] <= w_err_nxt;
      end
    end
  end

  assign bif.req_ready = (r_state == IDLE);
  assign bif.BREQ      = (r_state == REQUEST) || (r_state == XFER);
  assign bif.bus_valid = (r_state == XFER);
  assign bif.bus_write = bif.bus_valid & r_write;
  assign bif.bus_addr  = bif.bus_valid ? r_addr  : '0;
  assign bif.bus_wdata = bif.bus_valid ? r_wdata : '0;
  assign bif.rsp_valid = r_rsp_flags[RSP_VLD_BIT];
  assign bif.rsp_err   = r_rsp_flags[RSP_ERR_BIT];
  assign bif.rsp_rdata = r_rsp_flags[RSP_VLD_BIT] ? r_rdata : '0;

endmodule

// File: tb/tb_bus_master_requester.sv
// Directed bench for bus_master_requester with a two-register arbiter model,
// a wait-state slave model and a response scoreboard.
module tb_bus_master_requester;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_master_requester_if #(.AW(16), .DW(8)) bif ();

  bus_master_requester #(.AW(16), .DW(8), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb[$];

  logic       grant_en;
  logic       gdrop;
  logic       r_g1;
  logic       r_g2;
  int         slv_wait;
  logic [7:0] slv_rdata;
  int         scnt;

  // Arbiter model: grant registered twice from BREQ.
  always @(posedge clk) begin
    if (rst) begin
      r_g1 <= 1'b0;
      r_g2 <= 1'b0;
    end else begin
      r_g1 <= bif.BREQ & grant_en;
      r_g2 <= r_g1;
    end
  end
  assign bif.BGRANT = r_g2 & ~gdrop;

  always @(posedge clk) begin
    if (!bif.bus_valid || bif.bus_ready) scnt <= 0;
    else scnt <= scnt + 1;
  end
  assign bif.bus_ready = bif.bus_valid && (scnt == slv_wait);
  assign bif.bus_rdata = slv_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bif.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("rsp_err", {31'd0, bif.rsp_err}, {31'd0, e[8]});
        check("rsp_rdata", {24'd0, bif.rsp_rdata}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                       input logic exp_err, input logic [7:0] exp_rd,
                       input logic push, input logic hold);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    bif.req_write = wr;
    bif.req_addr  = addr;
    bif.req_wdata = wd;
    bif.req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bif.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", {31'd0, ok}, 32'd1);
    if (push) sb.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    if (!hold) bif.req_valid = 1'b0;
  endtask

  task automatic run_to_rsp(input int maxc, input logic [15:0] eaddr, input logic [7:0] ewd,
                            input logic ewr, output int rsp_k, output int bv_n,
                            output int breq_low_k);
    int rk, bn, bl;
    rk = -1;
    bn = 0;
    bl = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (bif.bus_valid) begin
        bn++;
        check("bus_addr", {16'd0, bif.bus_addr}, {16'd0, eaddr});
        check("bus_wdata", {24'd0, bif.bus_wdata}, {24'd0, ewd});
        check("bus_write", {31'd0, bif.bus_write}, {31'd0, ewr});
      end
      if (bl < 0 && !bif.BREQ) bl = k;
      if (bif.rsp_valid) begin
        rk = k;
        break;
      end
    end
    check("rsp_seen", {31'd0, (rk > 0)}, 32'd1);
    rsp_k = rk;
    bv_n = bn;
    breq_low_k = bl;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bif.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rk, bn, bl, acc_k, low_k;
    logic bg_prev, saw;
    rst = 1'b1;
    grant_en = 1'b1;
    gdrop = 1'b0;
    slv_wait = 0;
    slv_rdata = 8'h00;
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_addr = '0;
    bif.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, bif.req_ready}, 32'd1);
    check("rst_breq", {31'd0, bif.BREQ}, 32'd0);
    check("rst_bus_valid", {31'd0, bif.bus_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bif.rsp_err}, 32'd0);
    check("rst_rsp_rdata", {24'd0, bif.rsp_rdata}, 32'd0);
    check("rst_bus_addr", {16'd0, bif.bus_addr}, 32'd0);
    rst = 1'b0;

    // Write to an idle bus, zero-wait slave.
    issue(1'b1, 16'h0012, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0);
    run_to_rsp(20, 16'h0012, 8'hA5, 1'b1, rk, bn, bl);
    check("wr_rsp_cycle", rk, 5);
    check("wr_bv_cycles", bn, 1);
    check("wr_breq_low", bl, 5);
    wait_idle("wr_idle");

    // Read with 3 wait states.
    slv_wait = 3;
    slv_rdata = 8'h3C;
    issue(1'b0, 16'h0100, 8'h77, 1'b0, 8'h3C, 1'b1, 1'b0);
    run_to_rsp(30, 16'h0100, 8'h77, 1'b0, rk, bn, bl);
    check("rd_bv_cycles", bn, 4);
    check("rd_rsp_cycle", rk, 8);
    wait_idle("rd_idle");
    slv_wait = 0;

    // Grant withheld.
    grant_en = 1'b0;
    slv_rdata = 8'h5A;
`ifdef MASTER_TIMEOUT_EN
    issue(1'b0, 16'h0200, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    low_k = -1;
    saw = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (!bif.BREQ) begin
        low_k = k;
        saw = bif.rsp_valid;
        break;
      end
    end
    check("to_breq_low", low_k, 256);
    check("to_rsp_at_drop", {31'd0, saw}, 32'd1);
    grant_en = 1'b1;
    wait_idle("to_idle");
`else
    issue(1'b0, 16'h0200, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0);
    saw = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bif.rsp_valid) saw = 1'b1;
    end
    check("to_breq_300", {31'd0, bif.BREQ}, 32'd1);
    check("to_no_rsp", {31'd0, saw}, 32'd0);
    grant_en = 1'b1;
    run_to_rsp(20, 16'h0200, 8'h00, 1'b0, rk, bn, bl);
    check("to_late_bv", bn, 1);
    wait_idle("to_idle");
`endif

    // Grant lost mid-transfer with bus_ready low.
    slv_wait = 10;
    issue(1'b0, 16'h0077, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.bus_valid) begin
        saw = 1'b1;
        break;
      end
    end
    check("gl_bus_valid_seen", {31'd0, saw}, 32'd1);
    @(negedge clk);
    gdrop = 1'b1;
    @(negedge clk);
    check("gl_rsp_valid", {31'd0, bif.rsp_valid}, 32'd1);
    check("gl_rsp_err", {31'd0, bif.rsp_err}, 32'd1);
    check("gl_bus_valid", {31'd0, bif.bus_valid}, 32'd0);
    gdrop = 1'b0;
    wait_idle("gl_idle");
    slv_wait = 0;

    // Back-to-back with req_valid held.
    issue(1'b1, 16'h0040, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1);
    bif.req_addr = 16'h0041;
    bif.req_wdata = 8'h22;
    acc_k = -1;
    bg_prev = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bif.req_ready) begin
        acc_k = k;
        break;
      end
      bg_prev = bif.BGRANT;
    end
    check("b2b_accept_cycle", acc_k, 8);
    check("b2b_bgrant_prev", {31'd0, bg_prev}, 32'd0);
    sb.push_back({1'b0, 8'h00});
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    run_to_rsp(20, 16'h0041, 8'h22, 1'b1, rk, bn, bl);
    check("b2b_rsp2_cycle", rk, 5);
    wait_idle("b2b_idle");

    // Reset during XFER: no response pulse.
    slv_wait = 10;
    issue(1'b0, 16'h0300, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.bus_valid) begin
        saw = 1'b1;
        break;
      end
    end
    check("rx_bus_valid_seen", {31'd0, saw}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rx_breq", {31'd0, bif.BREQ}, 32'd0);
    check("rx_bus_valid", {31'd0, bif.bus_valid}, 32'd0);
    check("rx_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    check("rx_req_ready", {31'd0, bif.req_ready}, 32'd1);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    slv_wait = 0;

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
